// File: rtl/dvid_pkg.sv
// Shared DVI/TMDS definitions: symbol type, control and clock-lane symbols, popcount helper.
package dvid_pkg;

   typedef logic [9:0] tmds_sym_t;

   localparam tmds_sym_t CTL_SYM_00 = 10'b1101010100;
   localparam tmds_sym_t CTL_SYM_01 = 10'b0010101011;
   localparam tmds_sym_t CTL_SYM_10 = 10'b0101010100;
   localparam tmds_sym_t CTL_SYM_11 = 10'b1010101011;
   localparam tmds_sym_t CLK_SYMBOL = 10'b0000011111;

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
      return n;
   endfunction

   function automatic tmds_sym_t ctl_symbol(input logic [1:0] c);
      tmds_sym_t s;
      case (c)
         2'b00:   s = CTL_SYM_00;
         2'b01:   s = CTL_SYM_01;
         2'b10:   s = CTL_SYM_10;
         default: s = CTL_SYM_11;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/tmds_channel_encoder.sv
// One TMDS lane: stage 1 transition-minimised q_m, stage 2 DC-balanced symbol with
// running disparity counter cnt (signed, bounded to -10..+10).
module tmds_channel_encoder
   import dvid_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       blank,
   input  logic [1:0] ctl,
   input  logic [7:0] data,
   output tmds_sym_t  symbol
);

   logic              s1_blank;
   logic [1:0]        s1_ctl;
   logic [8:0]        s1_qm;
   logic [8:0]        qm_next;
   logic [3:0]        n1_d;
   logic [3:0]        n1_q;
   logic              use_xnor;
   logic signed [4:0] cnt;
   logic signed [4:0] cnt_next;
   logic signed [5:0] diff;
   logic signed [5:0] cnt_ext;
   logic signed [5:0] cnt_sum;
   tmds_sym_t         sym_next;

   always_comb begin
      n1_d       = popcount8(data);
      use_xnor   = (n1_d > 4'd4) || ((n1_d == 4'd4) && !data[0]);
      qm_next    = '0;
      qm_next[0] = data[0];
      for (int i = 1; i < 8; i++)
         qm_next[i] = use_xnor ? ~(qm_next[i-1] ^ data[i]) : (qm_next[i-1] ^ data[i]);
      qm_next[8] = ~use_xnor;
   end

   // diff = N1 - N0 of q_m[7:0], formed as 2*N1 - 8 to stay in 6-bit signed range
   always_comb begin
      n1_q     = popcount8(s1_qm[7:0]);
      diff     = $signed({1'b0, n1_q, 1'b0}) - 6'sd8;
      cnt_ext  = {cnt[4], cnt};
      sym_next = CTL_SYM_00;
      cnt_sum  = '0;
      if (s1_blank) begin
         sym_next = ctl_symbol(s1_ctl);
         cnt_sum  = '0;
      end else if ((cnt == 5'sd0) || (diff == 6'sd0)) begin
         sym_next = {~s1_qm[8], s1_qm[8], s1_qm[8] ? s1_qm[7:0] : ~s1_qm[7:0]};
         cnt_sum  = s1_qm[8] ? (cnt_ext + diff) : (cnt_ext - diff);
      end else if (((cnt > 5'sd0) && (diff > 6'sd0)) || ((cnt < 5'sd0) && (diff < 6'sd0))) begin
         sym_next = {1'b1, s1_qm[8], ~s1_qm[7:0]};
         cnt_sum  = cnt_ext + (s1_qm[8] ? 6'sd2 : 6'sd0) - diff;
      end else begin
         sym_next = {1'b0, s1_qm[8], s1_qm[7:0]};
         cnt_sum  = cnt_ext - (s1_qm[8] ? 6'sd0 : 6'sd2) + diff;
      end
      cnt_next = cnt_sum[4:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_blank <= 1'b1;
         s1_ctl   <= '0;
         s1_qm    <= '0;
         symbol   <= CTL_SYM_00;
         cnt      <= '0;
      end else begin
         s1_blank <= blank;
         s1_ctl   <= ctl;
         s1_qm    <= qm_next;
         symbol   <= sym_next;
         cnt      <= cnt_next;
      end
   end

endmodule

// File: rtl/tmds_encoder_array.sv
// NUM_CHANNELS-lane DVI TMDS encoder with colour expansion and lane-0 sync override.
// Optional TMDS_OUTPUT_REG_EN adds an output register stage (latency 3 instead of 2).
module tmds_encoder_array
   import dvid_pkg::*;
#(
   parameter int NUM_CHANNELS = 3,
   parameter int COLOUR_BITS  = 8
)
(
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                hsync,
   input  logic                                vsync,
   input  logic                                blank,
   input  logic [2*NUM_CHANNELS-1:0]           ctl,
   input  logic [NUM_CHANNELS*COLOUR_BITS-1:0] colour,
   output logic [10*NUM_CHANNELS-1:0]          symbols,
   output logic [9:0]                          clk_symbol,
   output logic                                symbol_valid
);

`ifdef TMDS_OUTPUT_REG_EN
   localparam int VALID_DEPTH = 3;
`else
   localparam int VALID_DEPTH = 2;
`endif

   logic [10*NUM_CHANNELS-1:0] lane_flat;
   logic [VALID_DEPTH-1:0]     valid_sr;
   logic                       unused_ctl;

   // lane 0 control comes from the sync inputs, so its ctl pair is never looked at
   assign unused_ctl = ^ctl[1:0];
   assign clk_symbol = CLK_SYMBOL;

   for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_lane
      logic [7:0] lane_data;
      logic [1:0] lane_ctl;

      for (genvar b = 0; b < 8; b++) begin : g_expand
         assign lane_data[7-b] = colour[i*COLOUR_BITS + COLOUR_BITS - 1 - (b % COLOUR_BITS)];
      end

      if (i == 0) begin : g_sync
         assign lane_ctl = {vsync, hsync};
      end else begin : g_ctl
         assign lane_ctl = ctl[2*i +: 2];
      end

      tmds_channel_encoder u_enc (
         .clk    (clk),
         .reset  (reset),
         .blank  (blank),
         .ctl    (lane_ctl),
         .data   (lane_data),
         .symbol (lane_flat[10*i +: 10])
      );
   end

`ifdef TMDS_OUTPUT_REG_EN
   always_ff @(posedge clk) begin
      if (reset) symbols <= {NUM_CHANNELS{CTL_SYM_00}};
      else       symbols <= lane_flat;
   end
`else
   assign symbols = lane_flat;
`endif

   always_ff @(posedge clk) begin
      if (reset) valid_sr <= '0;
      else       valid_sr <= {valid_sr[VALID_DEPTH-2:0], 1'b1};
   end

   assign symbol_valid = valid_sr[VALID_DEPTH-1];

endmodule
